// File: rtl/univ_shift_reg.sv
// Universal shift register: parallel load plus multi-step shift/rotate/arithmetic commands.
// Define UNIV_SHIFT_REG_PARITY_EN to add a registered parity output tracking ^q_out.
module univ_shift_reg #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d_par,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [CNT_W-1:0] amount,
  input  logic             d_in,
  output logic [WIDTH-1:0] q_out,
  output logic             s_out,
  output logic             busy,
  output logic             done
`ifdef UNIV_SHIFT_REG_PARITY_EN
  ,
  output logic             parity
`endif
);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  localparam logic [CNT_W-1:0] CntMax  = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CntZero = '0;

  state_e           state_q;
  logic [2:0]       mode_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] step_q;
  logic             step_s;
  logic [WIDTH-1:0] q_d;

  // One step of the latched mode; reserved encodings hold both q and s.
  always_comb begin
    step_q = q_out;
    step_s = s_out;
    case (mode_q)
      3'b000: begin
        step_q = {q_out[WIDTH-2:0], d_in};
        step_s = q_out[WIDTH-1];
      end
      3'b001: begin
        step_q = {d_in, q_out[WIDTH-1:1]};
        step_s = q_out[0];
      end
      3'b010: begin
        step_q = {q_out[WIDTH-2:0], q_out[WIDTH-1]};
        step_s = q_out[WIDTH-1];
      end
      3'b011: begin
        step_q = {q_out[0], q_out[WIDTH-1:1]};
        step_s = q_out[0];
      end
      3'b100: begin
        step_q = {q_out[WIDTH-1], q_out[WIDTH-1:1]};
        step_s = q_out[0];
      end
      default: begin
        step_q = q_out;
        step_s = s_out;
      end
    endcase
  end

  always_comb begin
    q_d = q_out;
    if (state_q == StIdle && load) begin
      q_d = d_par;
    end else if (state_q == StShift) begin
      q_d = step_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      mode_q  <= 3'b000;
      cnt_q   <= CntZero;
      q_out   <= '0;
      s_out   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef UNIV_SHIFT_REG_PARITY_EN
      parity  <= 1'b0;
`endif
    end else begin
      done   <= 1'b0;
      q_out  <= q_d;
`ifdef UNIV_SHIFT_REG_PARITY_EN
      parity <= ^q_d;
`endif
      case (state_q)
        StIdle: begin
          // load wins over start; a start seen alongside load is dropped.
          if (!load && start) begin
            if (amount == CntZero) begin
              done <= 1'b1;
            end else begin
              mode_q  <= mode;
              cnt_q   <= (amount > CntMax) ? CntMax : amount;
              busy    <= 1'b1;
              state_q <= StShift;
            end
          end
        end
        StShift: begin
          s_out <= step_s;
          cnt_q <= cnt_q - CntOne;
          if (cnt_q == CntOne) begin
            state_q <= StIdle;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed self-checking bench for univ_shift_reg (WIDTH=8).
// Parity checks are compiled in when UNIV_SHIFT_REG_PARITY_EN is defined.
module tb_univ_shift_reg;

  localparam int unsigned Width = 8;
  localparam int unsigned CntW  = 4;

  logic             clk;
  logic             rst;
  logic             load;
  logic [Width-1:0] d_par;
  logic             start;
  logic [2:0]       mode;
  logic [CntW-1:0]  amount;
  logic             d_in;
  logic [Width-1:0] q_out;
  logic             s_out;
  logic             busy;
  logic             done;
`ifdef UNIV_SHIFT_REG_PARITY_EN
  logic             parity;
`endif

  int n_checks;
  int n_fail;
  int n;

  univ_shift_reg #(.WIDTH(Width)) dut (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .d_par  (d_par),
    .start  (start),
    .mode   (mode),
    .amount (amount),
    .d_in   (d_in),
    .q_out  (q_out),
    .s_out  (s_out),
    .busy   (busy),
    .done   (done)
`ifdef UNIV_SHIFT_REG_PARITY_EN
    ,
    .parity (parity)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [Width-1:0] v);
    load  = 1'b1;
    d_par = v;
    tick();
    load  = 1'b0;
  endtask

  // Issues a command and returns the number of sampled cycles busy stayed high.
  task automatic run_cmd(input logic [2:0] m, input logic [CntW-1:0] a, output int cycles);
    start  = 1'b1;
    mode   = m;
    amount = a;
    tick();
    start  = 1'b0;
    cycles = 0;
    while (busy && cycles < 40) begin
      cycles++;
      tick();
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    load     = 1'b0;
    d_par    = '0;
    start    = 1'b0;
    mode     = 3'b000;
    amount   = '0;
    d_in     = 1'b0;
    #1;
    check_eq("reset_q", 32'(q_out), 32'h0);
    check_eq("reset_s", 32'(s_out), 32'h0);
    check_eq("reset_busy", 32'(busy), 32'h0);
    check_eq("reset_done", 32'(done), 32'h0);
`ifdef UNIV_SHIFT_REG_PARITY_EN
    check_eq("reset_parity", 32'(parity), 32'h0);
`endif
    tick();
    rst = 1'b0;
    tick();

    // Rotate left by 3.
    do_load(8'hA5);
    check_eq("load_a5", 32'(q_out), 32'hA5);
    run_cmd(3'b010, 4'd3, n);
    check_eq("rol_busy_cycles", 32'(n), 32'd3);
    check_eq("rol_q", 32'(q_out), 32'h2D);
    check_eq("rol_s", 32'(s_out), 32'h1);
    check_eq("rol_done", 32'(done), 32'h1);
    tick();
    check_eq("rol_done_once", 32'(done), 32'h0);

    // Reserved mode runs full count but holds q and s.
    run_cmd(3'b111, 4'd2, n);
    check_eq("rsv_busy_cycles", 32'(n), 32'd2);
    check_eq("rsv_q", 32'(q_out), 32'h2D);
    check_eq("rsv_s", 32'(s_out), 32'h1);
    check_eq("rsv_done", 32'(done), 32'h1);

    // Arithmetic shift right by 2; load must not touch s_out.
    do_load(8'h90);
    check_eq("load_keeps_s", 32'(s_out), 32'h1);
    run_cmd(3'b100, 4'd2, n);
    check_eq("asr_busy_cycles", 32'(n), 32'd2);
    check_eq("asr_q", 32'(q_out), 32'hE4);
    check_eq("asr_s", 32'(s_out), 32'h0);

    // Full-width rotate returns the original value.
    run_cmd(3'b010, 4'd8, n);
    check_eq("rol8_busy_cycles", 32'(n), 32'd8);
    check_eq("rol8_q", 32'(q_out), 32'hE4);

    // Clamp with serial fill from reset.
    rst = 1'b1;
    tick();
    rst  = 1'b0;
    d_in = 1'b1;
    run_cmd(3'b001, 4'd10, n);
    check_eq("clamp_busy_cycles", 32'(n), 32'd8);
    check_eq("clamp_q", 32'(q_out), 32'hFF);
    check_eq("clamp_s", 32'(s_out), 32'h0);
    check_eq("clamp_done", 32'(done), 32'h1);
    tick();
    check_eq("clamp_done_once", 32'(done), 32'h0);
    d_in = 1'b0;

    // Zero amount.
    run_cmd(3'b010, 4'd0, n);
    check_eq("zero_busy_cycles", 32'(n), 32'd0);
    check_eq("zero_done", 32'(done), 32'h1);
    check_eq("zero_q", 32'(q_out), 32'hFF);
    tick();
    check_eq("zero_done_once", 32'(done), 32'h0);

    // load and start together: only the load happens.
    load   = 1'b1;
    d_par  = 8'h3C;
    start  = 1'b1;
    mode   = 3'b000;
    amount = 4'd3;
    tick();
    load   = 1'b0;
    start  = 1'b0;
    check_eq("contend_q", 32'(q_out), 32'h3C);
    check_eq("contend_busy", 32'(busy), 32'h0);
    tick();
    check_eq("contend_busy_later", 32'(busy), 32'h0);
    check_eq("contend_done", 32'(done), 32'h0);

    // Load during busy is ignored.
    start  = 1'b1;
    mode   = 3'b011;
    amount = 4'd2;
    tick();
    start  = 1'b0;
    load   = 1'b1;
    d_par  = 8'h00;
    tick();
    load   = 1'b0;
    check_eq("busy_load_busy", 32'(busy), 32'h1);
    check_eq("busy_load_mid_q", 32'(q_out), 32'h1E);
    tick();
    check_eq("busy_load_done", 32'(done), 32'h1);
    check_eq("busy_load_q", 32'(q_out), 32'h0F);

    // Reset mid-command.
    do_load(8'hFF);
    start  = 1'b1;
    mode   = 3'b000;
    amount = 4'd5;
    tick();
    start  = 1'b0;
    tick();
    tick();
    check_eq("mid_q_before_rst", 32'(q_out), 32'hFC);
    check_eq("mid_busy_before_rst", 32'(busy), 32'h1);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_q", 32'(q_out), 32'h0);
    check_eq("mid_rst_busy", 32'(busy), 32'h0);
    check_eq("mid_rst_done", 32'(done), 32'h0);
    tick();
    rst = 1'b0;
    n   = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done || busy) n++;
    end
    check_eq("mid_no_done_after_rst", 32'(n), 32'd0);

`ifdef UNIV_SHIFT_REG_PARITY_EN
    do_load(8'h07);
    check_eq("par_load07", 32'(parity), 32'h1);
    start  = 1'b1;
    mode   = 3'b010;
    amount = 4'd1;
    tick();
    start  = 1'b0;
    check_eq("par_rol_busy", 32'(parity), 32'h1);
    tick();
    check_eq("par_rol_q", 32'(q_out), 32'h0E);
    check_eq("par_rol", 32'(parity), 32'h1);
    d_in   = 1'b1;
    start  = 1'b1;
    mode   = 3'b000;
    amount = 4'd1;
    tick();
    start  = 1'b0;
    check_eq("par_shl_busy", 32'(parity), 32'h1);
    tick();
    check_eq("par_shl_q", 32'(q_out), 32'h1D);
    check_eq("par_shl", 32'(parity), 32'h0);
    d_in = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
